// File: rtl/vrf_port_arbiter.sv
// ---------------------------------------------------------------------------
// vrf_port_arbiter
//
// Controller for the single-port vector register file macro. After reset it
// writes zero into every entry (INIT). It then shares the SRAM port between
// two requesters (RUN):
//   port 0 : vector execution pipeline
//   port 1 : vector load/store unit
// Arbitration is round-robin with a same-cycle grant. Read data comes back
// one cycle after the grant and is flagged to the port that issued the read.
//
// Ports
//   clk, reset                 single clock, synchronous active-high reset
//   req_x / gnt_x              access request / same-cycle acceptance
//   addr_x, we_x               entry address, 1 = write / 0 = read
//   write_mask_x, data_w_x     per-group write enables and write data
//   rvalid_x, data_r           read data valid per port, shared read data
//   init_done                  clear sweep finished
//   rf_en, rf_we, rf_addr,
//   rf_write_mask, rf_data_w   macro command (active-high enables)
//   rf_data_r                  macro read data, valid one cycle after a read
// ---------------------------------------------------------------------------
module vrf_port_arbiter #(
    parameter int NUM_ELEMS           = 8,
    parameter int ELEM_SIZE           = 16,
    parameter int ENABLES_PER_ELEMENT = 4,
    parameter int VRF_SIZE            = 32,
    localparam int MW = NUM_ELEMS * ENABLES_PER_ELEMENT,
    localparam int W  = NUM_ELEMS * ELEM_SIZE,
    localparam int AW = $clog2(VRF_SIZE)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req_0,
    input  logic          req_1,
    output logic          gnt_0,
    output logic          gnt_1,
    input  logic [AW-1:0] addr_0,
    input  logic [AW-1:0] addr_1,
    input  logic          we_0,
    input  logic          we_1,
    input  logic [MW-1:0] write_mask_0,
    input  logic [MW-1:0] write_mask_1,
    input  logic [W-1:0]  data_w_0,
    input  logic [W-1:0]  data_w_1,
    output logic          rvalid_0,
    output logic          rvalid_1,
    output logic [W-1:0]  data_r,
    output logic          init_done,
    output logic          rf_en,
    output logic          rf_we,
    output logic [AW-1:0] rf_addr,
    output logic [MW-1:0] rf_write_mask,
    output logic [W-1:0]  rf_data_w,
    input  logic [W-1:0]  rf_data_r
);

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [AW-1:0] ADDR_ONE  = AW'(1);
    localparam logic [AW-1:0] ADDR_LAST = AW'(VRF_SIZE - 1);

    state_t        state_r;
    logic [AW-1:0] init_addr_r;
    logic          last_gnt_r;     // index of the most recently granted port
    logic          rvalid_0_r;
    logic          rvalid_1_r;
    logic          init_done_r;
    logic          gnt_0_s;
    logic          gnt_1_s;

    // Round-robin grant; nothing is granted while reset is high so that a
    // request in the reset cycle never reaches the macro or yields rvalid.
    always_comb begin
        gnt_0_s = 1'b0;
        gnt_1_s = 1'b0;
        if ((state_r == ST_RUN) && !reset) begin
            if (req_0 && req_1) begin
                if (last_gnt_r == 1'b1) begin
                    gnt_0_s = 1'b1;
                end else begin
                    gnt_1_s = 1'b1;
                end
            end else if (req_0) begin
                gnt_0_s = 1'b1;
            end else if (req_1) begin
                gnt_1_s = 1'b1;
            end else begin
                gnt_0_s = 1'b0;
                gnt_1_s = 1'b0;
            end
        end else begin
            gnt_0_s = 1'b0;
            gnt_1_s = 1'b0;
        end
    end

    // Macro command mux: clear sweep in INIT, granted port in RUN.
    // With no grant the address/data fields follow port 0 (don't-care).
    always_comb begin
        rf_en         = 1'b0;
        rf_we         = 1'b0;
        rf_addr       = addr_0;
        rf_write_mask = write_mask_0;
        rf_data_w     = data_w_0;
        case (state_r)
            ST_INIT: begin
                rf_en         = 1'b1;
                rf_we         = 1'b1;
                rf_addr       = init_addr_r;
                rf_write_mask = {MW{1'b1}};
                rf_data_w     = {W{1'b0}};
            end
            ST_RUN: begin
                if (gnt_1_s) begin
                    rf_en         = 1'b1;
                    rf_we         = we_1;
                    rf_addr       = addr_1;
                    rf_write_mask = write_mask_1;
                    rf_data_w     = data_w_1;
                end else if (gnt_0_s) begin
                    rf_en         = 1'b1;
                    rf_we         = we_0;
                end else begin
                    rf_en         = 1'b0;
                    rf_we         = 1'b0;
                end
            end
            default: begin
                rf_en = 1'b0;
                rf_we = 1'b0;
            end
        endcase
    end

    // Controller FSM: clear sweep, round-robin history and read-valid tags.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_INIT;
            init_addr_r <= {AW{1'b0}};
            last_gnt_r  <= 1'b1;
            rvalid_0_r  <= 1'b0;
            rvalid_1_r  <= 1'b0;
            init_done_r <= 1'b0;
        end else begin
            case (state_r)
                ST_INIT: begin
                    rvalid_0_r <= 1'b0;
                    rvalid_1_r <= 1'b0;
                    if (init_addr_r == ADDR_LAST) begin
                        state_r     <= ST_RUN;
                        init_addr_r <= {AW{1'b0}};
                        init_done_r <= 1'b1;
                    end else begin
                        init_addr_r <= init_addr_r + ADDR_ONE;
                    end
                end
                ST_RUN: begin
                    if (gnt_0_s) begin
                        last_gnt_r <= 1'b0;
                    end else if (gnt_1_s) begin
                        last_gnt_r <= 1'b1;
                    end else begin
                        last_gnt_r <= last_gnt_r;
                    end
                    rvalid_0_r <= gnt_0_s & ~we_0;
                    rvalid_1_r <= gnt_1_s & ~we_1;
                end
                default: begin
                    state_r     <= ST_INIT;
                    init_addr_r <= {AW{1'b0}};
                    rvalid_0_r  <= 1'b0;
                    rvalid_1_r  <= 1'b0;
                    init_done_r <= 1'b0;
                end
            endcase
        end
    end

    assign gnt_0     = gnt_0_s;
    assign gnt_1     = gnt_1_s;
    assign rvalid_0  = rvalid_0_r;
    assign rvalid_1  = rvalid_1_r;
    assign init_done = init_done_r;
    assign data_r    = rf_data_r;

endmodule

// File: tb/tb_vrf_port_arbiter.sv
module tb_vrf_port_arbiter;

    localparam int W  = 128;
    localparam int MW = 32;
    localparam int AW = 5;
    localparam int N  = 32;

    typedef struct packed {
        logic         port;
        logic [W-1:0] data;
    } rd_t;

    logic          clk;
    logic          reset;
    logic          req_0, req_1, gnt_0, gnt_1;
    logic [AW-1:0] addr_0, addr_1;
    logic          we_0, we_1;
    logic [MW-1:0] write_mask_0, write_mask_1;
    logic [W-1:0]  data_w_0, data_w_1;
    logic          rvalid_0, rvalid_1;
    logic [W-1:0]  data_r;
    logic          init_done;
    logic          rf_en, rf_we;
    logic [AW-1:0] rf_addr;
    logic [MW-1:0] rf_write_mask;
    logic [W-1:0]  rf_data_w;
    logic [W-1:0]  rf_data_r;

    logic [W-1:0]  sram [N];     // macro model driven by rf_*
    logic [W-1:0]  ref_mem [N];  // expected contents, updated from stimulus
    rd_t           exp_q [$];
    int            compared;
    int            mismatched;

    vrf_port_arbiter dut (
        .clk(clk), .reset(reset),
        .req_0(req_0), .req_1(req_1), .gnt_0(gnt_0), .gnt_1(gnt_1),
        .addr_0(addr_0), .addr_1(addr_1), .we_0(we_0), .we_1(we_1),
        .write_mask_0(write_mask_0), .write_mask_1(write_mask_1),
        .data_w_0(data_w_0), .data_w_1(data_w_1),
        .rvalid_0(rvalid_0), .rvalid_1(rvalid_1), .data_r(data_r),
        .init_done(init_done),
        .rf_en(rf_en), .rf_we(rf_we), .rf_addr(rf_addr),
        .rf_write_mask(rf_write_mask), .rf_data_w(rf_data_w),
        .rf_data_r(rf_data_r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port macro: masked write (4 bits per enable), read data next cycle.
    always @(posedge clk) begin
        if (rf_en) begin
            if (rf_we) begin
                for (int k = 0; k < MW; k++) begin
                    if (rf_write_mask[k]) sram[rf_addr][k*4 +: 4] <= rf_data_w[k*4 +: 4];
                end
            end else begin
                rf_data_r <= sram[rf_addr];
            end
        end
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Compare read-return outputs against the scoreboard (latency one cycle).
    task automatic check_out();
        rd_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("rvalid_0", rvalid_0, e.port == 1'b0);
            chk("rvalid_1", rvalid_1, e.port == 1'b1);
            chk("data_r", data_r, e.data);
        end else begin
            chk("rvalid_idle", {rvalid_0, rvalid_1}, 2'b00);
        end
    endtask

    // Clear sweep: n cycles of zero writes starting at address 0.
    task automatic sweep(input int n, input logic req_on);
        for (int k = 0; k < n; k++) begin
            reset = 1'b0; req_0 = req_on; req_1 = req_on; we_0 = 1'b0; we_1 = 1'b0;
            #1;
            chk("sweep", {rf_en, rf_we, rf_addr, rf_write_mask, rf_data_w, gnt_0, gnt_1, init_done},
                {1'b1, 1'b1, k[4:0], 32'hFFFF_FFFF, 128'h0, 3'b000});
            ref_mem[k] = {W{1'b0}};
            tick();
            check_out();
        end
    endtask

    // One RUN cycle with directed inputs and the expected grant pair.
    task automatic access(input logic r0, input logic r1,
                          input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                          input logic w0, input logic w1,
                          input logic [MW-1:0] m0, input logic [MW-1:0] m1,
                          input logic [W-1:0] d0, input logic [W-1:0] d1,
                          input logic eg0, input logic eg1);
        logic [AW-1:0] a;
        logic          w;
        logic [MW-1:0] m;
        logic [W-1:0]  d;
        reset = 1'b0;
        req_0 = r0; req_1 = r1; addr_0 = a0; addr_1 = a1; we_0 = w0; we_1 = w1;
        write_mask_0 = m0; write_mask_1 = m1; data_w_0 = d0; data_w_1 = d1;
        #1;
        chk("gnt", {gnt_0, gnt_1}, {eg0, eg1});
        if (eg0 || eg1) begin
            a = eg1 ? a1 : a0;
            w = eg1 ? w1 : w0;
            m = eg1 ? m1 : m0;
            d = eg1 ? d1 : d0;
            chk("rf_cmd", {rf_en, rf_we, rf_addr}, {1'b1, w, a});
            if (w) begin
                chk("rf_wdata", {rf_write_mask, rf_data_w}, {m, d});
                for (int k = 0; k < MW; k++) begin
                    if (m[k]) ref_mem[a][k*4 +: 4] = d[k*4 +: 4];
                end
            end else begin
                exp_q.push_back('{port: eg1, data: ref_mem[a]});
            end
        end else begin
            chk("rf_idle", {rf_en, rf_we}, 2'b00);
        end
        tick();
        check_out();
    endtask

    localparam logic [W-1:0]  PAT_A = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    localparam logic [W-1:0]  PAT_B = 128'hA5A5_5A5A_C3C3_3C3C_0F0F_F0F0_1111_EEEE;
    localparam logic [W-1:0]  ONES  = {W{1'b1}};
    localparam logic [W-1:0]  ZERO  = {W{1'b0}};
    localparam logic [MW-1:0] MALL  = {MW{1'b1}};
    localparam logic [MW-1:0] MNONE = {MW{1'b0}};

    initial begin
        compared = 0;
        mismatched = 0;
        for (int i = 0; i < N; i++) begin
            sram[i] = {4{32'hDEAD_BEEF}};
            ref_mem[i] = {4{32'hDEAD_BEEF}};
        end
        reset = 1'b1; req_0 = 1'b1; req_1 = 1'b1; we_0 = 1'b0; we_1 = 1'b0;
        addr_0 = 5'd0; addr_1 = 5'd0; write_mask_0 = MNONE; write_mask_1 = MNONE;
        data_w_0 = ZERO; data_w_1 = ZERO;
        tick();
        tick();
        // Reset state: nothing granted, no read valid, init not done.
        chk("reset_state", {gnt_0, gnt_1, rvalid_0, rvalid_1, init_done}, 5'b00000);

        // Reset and clear with requests low.
        sweep(N, 1'b0);
        chk("init_done_rise", init_done, 1'b1);
        access(1'b0, 1'b1, 5'd0, 5'd17, 1'b0, 1'b0, MNONE, MNONE, ZERO, ZERO, 1'b0, 1'b1);

        // Seed two entries, then conflicting reads alternate 0,1,0,1.
        access(1'b1, 1'b0, 5'd3, 5'd0, 1'b1, 1'b0, MALL, MNONE, PAT_A, ZERO, 1'b1, 1'b0);
        access(1'b0, 1'b1, 5'd0, 5'd9, 1'b0, 1'b1, MNONE, MALL, ZERO, PAT_B, 1'b0, 1'b1);
        access(1'b1, 1'b1, 5'd3, 5'd9, 1'b0, 1'b0, MNONE, MNONE, ZERO, ZERO, 1'b1, 1'b0);
        access(1'b1, 1'b1, 5'd3, 5'd9, 1'b0, 1'b0, MNONE, MNONE, ZERO, ZERO, 1'b0, 1'b1);
        access(1'b1, 1'b1, 5'd3, 5'd9, 1'b0, 1'b0, MNONE, MNONE, ZERO, ZERO, 1'b1, 1'b0);
        access(1'b1, 1'b1, 5'd3, 5'd9, 1'b0, 1'b0, MNONE, MNONE, ZERO, ZERO, 1'b0, 1'b1);

        // Partial write then immediate read by the other port.
        access(1'b1, 1'b0, 5'd5, 5'd0, 1'b1, 1'b0, 32'h0000_000F, MNONE, ONES, ZERO, 1'b1, 1'b0);
        access(1'b0, 1'b1, 5'd0, 5'd5, 1'b0, 1'b0, MNONE, MNONE, ZERO, ZERO, 1'b0, 1'b1);
        chk("partial_model", ref_mem[5], 128'h0000_0000_0000_0000_0000_0000_0000_FFFF);

        // Port 1 streams reads of 0..7.
        for (int i = 0; i < 8; i++) begin
            access(1'b0, 1'b1, 5'd0, i[4:0], 1'b0, 1'b0, MNONE, MNONE, ZERO, ZERO, 1'b0, 1'b1);
        end
        access(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, MNONE, MNONE, ZERO, ZERO, 1'b0, 1'b0);

        // Reset in the same cycle as a port 0 read: not granted, no rvalid.
        reset = 1'b1; req_0 = 1'b1; req_1 = 1'b0; we_0 = 1'b0; addr_0 = 5'd3;
        #1;
        chk("gnt_in_reset", {gnt_0, gnt_1}, 2'b00);
        tick();
        check_out();

        // Sweep restarts at 0; reset again at address 12.
        sweep(12, 1'b0);
        reset = 1'b1; req_0 = 1'b1; req_1 = 1'b1;
        #1;
        chk("gnt_mid_init_reset", {gnt_0, gnt_1}, 2'b00);
        tick();
        check_out();
        sweep(N, 1'b1);
        chk("init_done_again", init_done, 1'b1);

        // Entries were cleared; round-robin history reset so port 0 wins first.
        access(1'b1, 1'b1, 5'd3, 5'd9, 1'b0, 1'b0, MNONE, MNONE, ZERO, ZERO, 1'b1, 1'b0);
        access(1'b1, 1'b1, 5'd3, 5'd9, 1'b0, 1'b0, MNONE, MNONE, ZERO, ZERO, 1'b0, 1'b1);
        access(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, MNONE, MNONE, ZERO, ZERO, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/vrf_port_arbiter.md
# vrf_port_arbiter

Controller in front of the single-port vector register file macro (NUM_ELEMS x ELEM_SIZE bits wide, VRF_SIZE entries, per-sub-element write enables). It zero-initialises every VRF entry after reset, then shares the one SRAM port between two requesters:

- port 0: vector execution pipeline
- port 1: vector load/store unit

Arbitration is round-robin with a single-cycle grant, and read data is routed back to the requester that issued the read.

## Interface
- NUM_ELEMS, 8, elements per vector word
- ELEM_SIZE, 16, bits per element
- ENABLES_PER_ELEMENT, 4, write-enable groups per element; MW = NUM_ELEMS*ENABLES_PER_ELEMENT, W = NUM_ELEMS*ELEM_SIZE, AW = $clog2(VRF_SIZE)
- VRF_SIZE, 32, number of VRF entries

Ports:
- clk  in  1  single clock
- reset  in  1  synchronous, active-high
- req_0, req_1  in  1  access request
- gnt_0, gnt_1  out  1  access accepted this cycle (combinational from req)
- addr_0, addr_1  in  AW  entry address
- we_0, we_1  in  1  1 = write, 0 = read
- write_mask_0, write_mask_1  in  MW  bit i*ENABLES_PER_ELEMENT+j enables group j of element i
- data_w_0, data_w_1  in  W  write data
- rvalid_0, rvalid_1  out  1  data_r valid for that port
- data_r  out  W  read data, shared; qualified by rvalid_x
- init_done  out  1  VRF clear sweep finished
- rf_en, rf_we  out  1  to macro: access enable and write enable (active-high)
- rf_addr  out  AW  to macro
- rf_write_mask  out  MW  to macro
- rf_data_w  out  W  to macro
- rf_data_r  in  W  from macro; valid one cycle after a read access

## Operation
The FSM has two states.

- **INIT**
  - Entered on reset. Address counter init_addr = 0; both gnt low.
  - Each cycle drives: rf_en=1, rf_we=1, rf_addr=init_addr, rf_write_mask all ones, rf_data_w=0.
  - init_addr increments each cycle.
  - After the write to VRF_SIZE-1, moves to RUN; init_done=1 from the next cycle on.
- **RUN**
  - Arbitration:
    - Exactly one port requesting: that port is granted.
    - Both requesting: the port not equal to last_gnt is granted.
    - last_gnt updates to the granted port on every grant and holds when there is no grant.
  - Granted port's addr, we, write_mask and data_w are muxed combinationally to rf_*; rf_en=1.
  - No grant: rf_en=0, rf_we=0; other rf_* are don't-care (driven from port 0).
  - Granted read (we=0) sets rvalid_x for the granted port one cycle later. data_r = rf_data_r, passed through unregistered.
  - Writes produce no rvalid.
  - A requester that is not granted keeps req high to retry. Req need not be held between cycles; gnt implies acceptance.
- Reset values:
  - state = INIT, init_addr = 0, last_gnt = 1 (port 0 wins the first conflict).
  - rvalid_0 = rvalid_1 = 0, init_done = 0.
  - gnt_0 = gnt_1 = 0 while in INIT.
- Reset asserted mid-INIT or mid-RUN:
  - Sweep restarts from address 0.
  - A read accepted in the cycle reset is high produces no rvalid.
  - Requests presented while reset is high are not granted.

## Timing
- Grant latency: 0 cycles (same cycle as req in RUN).
- Read latency: rvalid_x and data_r 1 cycle after the gnt cycle.
- Throughput: one access per cycle. Back-to-back reads to either port are fully pipelined; rvalid_0 and rvalid_1 are never high together.
- Write then read to the same address on consecutive cycles returns the new data (macro is write-before-next-read).
- INIT duration: exactly VRF_SIZE cycles after the cycle reset deasserts. The first grant is possible in cycle VRF_SIZE+1 counted from reset low, the same cycle init_done rises.
- Out-of-range addr (≥ VRF_SIZE when VRF_SIZE is not a power of 2) is passed through unchecked.

## Test plan
- **Reset and clear:** release reset, hold req low.
  - Expect 32 consecutive cycles of rf_en=rf_we=1, rf_addr 0..31, rf_data_w=0, mask all ones.
  - Then init_done=1; afterwards a read of addr 17 from port 1 returns 0 with rvalid_1 one cycle later.
- **Conflict round-robin:** in RUN, req_0=req_1=1 for 4 cycles, both reads.
  - Expect gnt sequence port 0,1,0,1 and rf_addr alternating addr_0/addr_1.
  - Expect rvalid_0/rvalid_1 alternating, starting one cycle after the first grant.
- **Partial write:** port 0 writes addr 5 with data_w=all ones, write_mask=32'h0000000F (groups 0-3 of element 0). Port 1 then reads addr 5.
  - Expect data_r = 128'h0000...FFFF with rvalid_1 only.
- **Single requester streaming:** port 1 issues 8 back-to-back reads, addr 0..7, with req_0 low.
  - Expect gnt_1 high for all 8 cycles and rvalid_1 high for 8 cycles, each delayed by 1.
- **Reset mid-INIT:** assert reset at init_addr=12 for one cycle.
  - Expect the sweep to restart at 0, init_done low for a further 32 cycles, and requests during INIT never granted.
- **Reset during read:** port 0 read granted in the same cycle reset is high.
  - Expect rvalid_0=0 in the following cycle and state INIT.
